shared_arbiter: RTL and testbench

SHARED_ARBITER -- requirements
Module: shared_arbiter

---
 rtl/shared_arbiter.sv | 103 ++++++++++
 tb/tb_shared_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_arbiter.sv
// Two-requester round-robin front end sharing one W-bit adder; grant 1 cycle, result 2 cycles after request edge.
// No queueing: requesters hold req until their grant; requests during CALC/DONE wait for IDLE (1 op per 3 cycles).
module shared_arbiter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic         req1,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         sel,
   output logic         busy,
   output logic         done0,
   output logic         done1,
   output logic [W:0]   sum
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t       state_q;
   logic         last_q;
   logic         sel_q;
   logic         busy_q;
   logic         gnt0_q, gnt1_q;
   logic         done0_q, done1_q;
   logic [W-1:0] op_a_q, op_b_q;
   logic [W:0]   sum_q;

   logic         any_req;
   logic         win;
   logic [W-1:0] mux_a, mux_b;
   logic [W:0]   add_res;

   // On a tie the requester that did not win last time goes; a lone request always wins.
   assign any_req = req0 | req1;
   assign win     = (req0 & req1) ? ~last_q : req1;
   assign mux_a   = win ? a1 : a0;
   assign mux_b   = win ? b1 : b0;
   assign add_res = {1'b0, op_a_q} + {1'b0, op_b_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  op_a_q  <= mux_a;
                  op_b_q  <= mux_b;
                  sel_q   <= win;
                  last_q  <= win;
                  gnt0_q  <= ~win;
                  gnt1_q  <= win;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               sum_q   <= add_res;
               done0_q <= ~sel_q;
               done1_q <= sel_q;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               state_q <= DONE;
            end
            DONE: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign sel   = sel_q;
   assign busy  = busy_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign sum   = sum_q;

endmodule

// File: tb/tb_shared_arbiter.sv
// Bench for shared_arbiter: W=1 vector table and alternation, W=4 corner sequences and randomized traffic.
module tb_shared_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // W=1 instance
   logic       r0_1 = 0, r1_1 = 0, a0_1 = 0, b0_1 = 0, a1_1 = 0, b1_1 = 0;
   logic       g0_1, g1_1, sel_1, busy_1, d0_1, d1_1;
   logic [1:0] sum_1;
   // W=4 instance
   logic       r0_4 = 0, r1_4 = 0;
   logic [3:0] a0_4 = 0, b0_4 = 0, a1_4 = 0, b1_4 = 0;
   logic       g0_4, g1_4, sel_4, busy_4, d0_4, d1_4;
   logic [4:0] sum_4;

   shared_arbiter #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0(r0_1), .a0(a0_1), .b0(b0_1), .req1(r1_1), .a1(a1_1), .b1(b1_1),
      .gnt0(g0_1), .gnt1(g1_1), .sel(sel_1), .busy(busy_1),
      .done0(d0_1), .done1(d1_1), .sum(sum_1));

   shared_arbiter #(.W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0(r0_4), .a0(a0_4), .b0(b0_4), .req1(r1_4), .a1(a1_4), .b1(b1_4),
      .gnt0(g0_4), .gnt1(g1_4), .sel(sel_4), .busy(busy_4),
      .done0(d0_4), .done1(d1_4), .sum(sum_4));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   typedef struct {
      logic r0, r1, a0, b0, a1, b1;
      logic eg0, eg1;
      logic [1:0] esum;
   } vec_t;
   vec_t tbl [8];

   // Reference model state for randomized traffic (edge-time arithmetic)
   int         e, g_edge, owner;
   logic       last_m, sel_m;
   logic [4:0] sum_m;
   logic [3:0] opa_m, opb_m;
   logic       eg0, eg1, ed0, ed1, ebusy;

   initial begin
      // r0 r1 a0 b0 a1 b1 -> gnt0 gnt1 sum ; pointer starts at 1 after reset
      tbl[0] = '{1,1, 1,1, 0,0, 1,0, 2'b10};
      tbl[1] = '{1,1, 0,0, 1,0, 0,1, 2'b01};
      tbl[2] = '{0,1, 0,0, 1,1, 0,1, 2'b10};
      tbl[3] = '{1,0, 0,1, 0,0, 1,0, 2'b01};
      tbl[4] = '{1,0, 0,0, 1,1, 1,0, 2'b00};
      tbl[5] = '{1,1, 1,1, 1,1, 0,1, 2'b10};
      tbl[6] = '{0,1, 1,1, 0,1, 0,1, 2'b01};
      tbl[7] = '{1,1, 1,0, 0,0, 1,0, 2'b01};

      // Reset values
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_w1", 32'({g0_1,g1_1,d0_1,d1_1,busy_1,sel_1,sum_1}), 32'd0);
      chk("rst_w4", 32'({g0_4,g1_4,d0_4,d1_4,busy_4,sel_4,sum_4}), 32'd0);

      // Table vectors; the first one is driven together with reset release
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         r0_1 = tbl[i].r0; r1_1 = tbl[i].r1;
         a0_1 = tbl[i].a0; b0_1 = tbl[i].b0; a1_1 = tbl[i].a1; b1_1 = tbl[i].b1;
         tick();
         chk("vec_gnt", 32'({g0_1,g1_1,d0_1,d1_1,busy_1,sel_1}),
             32'({tbl[i].eg0,tbl[i].eg1,2'b00,1'b1,tbl[i].eg1}));
         r0_1 = 0; r1_1 = 0;
         a0_1 = ~a0_1; b0_1 = ~b0_1; a1_1 = ~a1_1; b1_1 = ~b1_1;
         tick();
         chk("vec_done", 32'({g0_1,g1_1,d0_1,d1_1,busy_1,sum_1}),
             32'({2'b00,tbl[i].eg0,tbl[i].eg1,1'b1,tbl[i].esum}));
         tick();
         chk("vec_idle", 32'({g0_1,g1_1,d0_1,d1_1,busy_1,sum_1}),
             32'({5'b00000,tbl[i].esum}));
      end

      // Both requests held from reset: grants alternate 0,1,0,... every 3 cycles
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      r0_1 = 1; r1_1 = 1; a0_1 = 1; b0_1 = 0; a1_1 = 1; b1_1 = 1;
      for (int k = 0; k < 12; k++) begin
         int ph, turn, lt;
         logic [1:0] es;
         tick();
         ph = k % 3;
         turn = (k / 3) % 2;
         lt = (ph == 0) ? (turn ^ 1) : turn;
         es = (k == 0) ? 2'b00 : ((lt == 0) ? 2'b01 : 2'b10);
         chk("alt", 32'({g0_1,g1_1,d0_1,d1_1,busy_1,sum_1}),
             32'({ph==0 && turn==0, ph==0 && turn==1, ph==1 && turn==0, ph==1 && turn==1,
                  ph != 2, es}));
      end
      r0_1 = 0; r1_1 = 0;

      // W=4 lone req1 with carry out; sel follows the grant
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      r1_4 = 1; a1_4 = 4'hF; b1_4 = 4'h1;
      tick();
      chk("w4_gnt1", 32'({g0_4,g1_4,d1_4,sel_4,busy_4}), 32'b01011);
      r1_4 = 0; a1_4 = 4'h0; b1_4 = 4'h0;
      tick();
      chk("w4_done1", 32'({g1_4,d0_4,d1_4,sel_4,sum_4}), 32'({4'b0011,5'h10}));
      tick();
      chk("w4_idle1", 32'({d1_4,busy_4,sel_4,sum_4}), 32'({3'b001,5'h10}));

      // req1 raised during CALC of a req0 op is served at the first IDLE edge; a0/b0 toggled after capture
      r0_4 = 1; a0_4 = 4'h3; b0_4 = 4'h4;
      tick();
      chk("late_gnt0", 32'({g0_4,g1_4,sel_4}), 32'b100);
      r0_4 = 0; a0_4 = 4'hF; b0_4 = 4'hF;
      r1_4 = 1; a1_4 = 4'h2; b1_4 = 4'h5;
      tick();
      chk("late_done0", 32'({g1_4,d0_4,sum_4}), 32'({2'b01,5'h07}));
      tick();
      chk("late_wait", 32'({g0_4,g1_4,busy_4}), 32'b000);
      tick();
      chk("late_gnt1", 32'({g0_4,g1_4,sel_4,busy_4}), 32'b0111);
      r1_4 = 0;
      tick();
      chk("late_done1", 32'({d0_4,d1_4,sum_4}), 32'({2'b01,5'h07}));
      tick();

      // Reset pulse during CALC discards the operation
      r0_4 = 1; a0_4 = 4'h9; b0_4 = 4'h9;
      tick();
      chk("rc_gnt0", 32'({g0_4,busy_4}), 32'b11);
      r0_4 = 0;
      #2 rst_n = 1'b0;
      #1 chk("rc_async", 32'({g0_4,g1_4,d0_4,d1_4,busy_4,sel_4,sum_4}), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rc_quiet", 32'({g0_4,g1_4,d0_4,d1_4,busy_4,sum_4}), 32'd0);
      end
      r0_4 = 1;
      tick();
      chk("rc_regnt", 32'({g0_4,g1_4,busy_4}), 32'b101);
      r0_4 = 0;
      tick();
      chk("rc_redone", 32'({d0_4,d1_4,sum_4}), 32'({2'b10,5'h12}));
      tick();

      // Randomized traffic against the edge-time model
      rst_n = 1'b0;
      r0_4 = 0; r1_4 = 0;
      tick();
      rst_n = 1'b1;
      e = 0; g_edge = -100; owner = 0;
      last_m = 1'b1; sel_m = 1'b0; sum_m = '0; opa_m = '0; opb_m = '0;
      for (int c = 0; c < 1500; c++) begin
         logic q0, q1;
         @(posedge clk);
         e++;
         q0 = r0_4; q1 = r1_4;
         eg0 = 0; eg1 = 0; ed0 = 0; ed1 = 0;
         if (e == g_edge + 1) begin
            sum_m = {1'b0, opa_m} + {1'b0, opb_m};
            if (owner == 0) ed0 = 1; else ed1 = 1;
         end
         if (e >= g_edge + 3 && (q0 || q1)) begin
            owner = (q0 && q1) ? int'(!last_m) : int'(q1);
            last_m = owner[0];
            sel_m = owner[0];
            g_edge = e;
            opa_m = owner[0] ? a1_4 : a0_4;
            opb_m = owner[0] ? b1_4 : b0_4;
            if (owner == 0) eg0 = 1; else eg1 = 1;
         end
         ebusy = (e == g_edge) || (e == g_edge + 1);
         @(negedge clk);
         chk("rand", 32'({g0_4,g1_4,d0_4,d1_4,busy_4,sel_4,sum_4}),
             32'({eg0,eg1,ed0,ed1,ebusy,sel_m,sum_m}));
         if (r0_4 && g0_4) begin
            if ($urandom_range(3) != 0) begin
               r0_4 = 0; a0_4 = 4'($urandom); b0_4 = 4'($urandom);
            end
         end else if (!r0_4 && $urandom_range(2) == 0) begin
            a0_4 = 4'($urandom); b0_4 = 4'($urandom); r0_4 = 1;
         end
         if (r1_4 && g1_4) begin
            if ($urandom_range(3) != 0) begin
               r1_4 = 0; a1_4 = 4'($urandom); b1_4 = 4'($urandom);
            end
         end else if (!r1_4 && $urandom_range(2) == 0) begin
            a1_4 = 4'($urandom); b1_4 = 4'($urandom); r1_4 = 1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
